// File: rtl/cp0_tlb_regs.sv
// CP0 TLB register file (Index/Random/EntryLo0/1/Context/PageMask/Wired/BadVAddr/EntryHi) with TLB op sequencer.
// Latency: MFC0 read is combinational; TLBWI/TLBWR hold tlb_busy 1 cycle, TLBP/TLBR 2 cycles after acceptance.
// Backpressure: tlb_busy stalls the pipeline while an op is in flight; requests seen while busy are dropped.
// Optional feature: define TLB_WIRED_EN to implement the Wired register (otherwise Wired reads 0).
module cp0_tlb_regs #(
    parameter int TLB_ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cp0_we,
    input  logic [4:0]  cp0_waddr,
    input  logic [31:0] cp0_wdata,
    input  logic [4:0]  cp0_raddr,
    output logic [31:0] cp0_rdata,
    input  logic        tlbp_req,
    input  logic        tlbr_req,
    input  logic        tlbwi_req,
    input  logic        tlbwr_req,
    output logic        tlb_busy,
    output logic        TLBP,
    output logic        TLBR,
    output logic        TLBWI,
    output logic        TLBWR,
    output logic [31:0] EntryHi_o,
    output logic [31:0] PageMask_o,
    output logic [31:0] EntryLo0_o,
    output logic [31:0] EntryLo1_o,
    output logic [31:0] Index_o,
    output logic [31:0] Random_o,
    input  logic [31:0] EntryHi_i,
    input  logic [31:0] PageMask_i,
    input  logic [31:0] EntryLo0_i,
    input  logic [31:0] EntryLo1_i,
    input  logic [31:0] Index_i,
    input  logic        exc_tlb,
    input  logic [31:0] exc_vaddr
);

    localparam int               IDX_W   = $clog2(TLB_ENTRIES);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(TLB_ENTRIES - 1);

    localparam logic [31:0] ENTRYHI_MASK  = 32'hFFFF_E0FF;
    localparam logic [31:0] ENTRYLO_MASK  = 32'h03FF_FFFF;
    localparam logic [31:0] PAGEMASK_MASK = 32'h01FF_E000;

    localparam logic [4:0] REG_INDEX    = 5'd0;
    localparam logic [4:0] REG_RANDOM   = 5'd1;
    localparam logic [4:0] REG_ENTRYLO0 = 5'd2;
    localparam logic [4:0] REG_ENTRYLO1 = 5'd3;
    localparam logic [4:0] REG_CONTEXT  = 5'd4;
    localparam logic [4:0] REG_PAGEMASK = 5'd5;
    localparam logic [4:0] REG_WIRED    = 5'd6;
    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_ENTRYHI  = 5'd10;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_CAPTURE} state_t;
    typedef enum logic [1:0] {OP_TLBP, OP_TLBR, OP_TLBWI, OP_TLBWR} op_t;

    state_t state;
    op_t    op;
    op_t    req_op;
    logic   any_req;

    logic             index_p;
    logic [IDX_W-1:0] index_idx;
    logic [IDX_W-1:0] random_q;
    logic [IDX_W-1:0] wired_q;
    logic             wired_wr;
    logic [31:0]      entryhi_q;
    logic [31:0]      entrylo0_q;
    logic [31:0]      entrylo1_q;
    logic [31:0]      pagemask_q;
    logic [8:0]       ctx_ptebase;
    logic [18:0]      ctx_badvpn2;
    logic [31:0]      badvaddr_q;
    logic [31:0]      context_val;
    logic [31:0]      wired_val;

    logic wr_index, wr_lo0, wr_lo1, wr_ctx, wr_pmask, wr_hi;
    logic cap_p, cap_r;

    // Index_i carries only the probe-fail flag and the entry number; the rest is don't-care.
    logic unused_index_bits;
    assign unused_index_bits = ^Index_i[30:IDX_W];

    assign any_req = tlbp_req | tlbr_req | tlbwi_req | tlbwr_req;

    assign wr_index = cp0_we && (cp0_waddr == REG_INDEX);
    assign wr_lo0   = cp0_we && (cp0_waddr == REG_ENTRYLO0);
    assign wr_lo1   = cp0_we && (cp0_waddr == REG_ENTRYLO1);
    assign wr_ctx   = cp0_we && (cp0_waddr == REG_CONTEXT);
    assign wr_pmask = cp0_we && (cp0_waddr == REG_PAGEMASK);
    assign wr_hi    = cp0_we && (cp0_waddr == REG_ENTRYHI);

    // Results from the translation unit arrive during CAPTURE; an exception in that cycle discards them.
    assign cap_p = (state == ST_CAPTURE) && (op == OP_TLBP) && !exc_tlb;
    assign cap_r = (state == ST_CAPTURE) && (op == OP_TLBR) && !exc_tlb;

    // Pick one op if the pipeline ever raises several requests together.
    always_comb begin
        req_op = OP_TLBP;
        if (tlbp_req)       req_op = OP_TLBP;
        else if (tlbr_req)  req_op = OP_TLBR;
        else if (tlbwi_req) req_op = OP_TLBWI;
        else                req_op = OP_TLBWR;
    end

    // Op sequencer: accept in IDLE, pulse the command in ISSUE, collect results in CAPTURE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            op       <= OP_TLBP;
            tlb_busy <= 1'b0;
            TLBP     <= 1'b0;
            TLBR     <= 1'b0;
            TLBWI    <= 1'b0;
            TLBWR    <= 1'b0;
        end else begin
            TLBP  <= 1'b0;
            TLBR  <= 1'b0;
            TLBWI <= 1'b0;
            TLBWR <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        state    <= ST_ISSUE;
                        op       <= req_op;
                        tlb_busy <= 1'b1;
                        TLBP     <= (req_op == OP_TLBP);
                        TLBR     <= (req_op == OP_TLBR);
                        TLBWI    <= (req_op == OP_TLBWI);
                        TLBWR    <= (req_op == OP_TLBWR);
                    end
                end
                ST_ISSUE: begin
                    if (exc_tlb || (op == OP_TLBWI) || (op == OP_TLBWR)) begin
                        state    <= ST_IDLE;
                        tlb_busy <= 1'b0;
                    end else begin
                        state <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    state    <= ST_IDLE;
                    tlb_busy <= 1'b0;
                end
                default: begin
                    state    <= ST_IDLE;
                    tlb_busy <= 1'b0;
                end
            endcase
        end
    end

`ifdef TLB_WIRED_EN
    assign wired_wr = wr_ctx ? 1'b0 : (cp0_we && (cp0_waddr == REG_WIRED));

    // Wired boundary for the Random counter; only MTC0 changes it.
    always_ff @(posedge clk) begin
        if (rst)           wired_q <= '0;
        else if (wired_wr) wired_q <= cp0_wdata[IDX_W-1:0];
    end
`else
    assign wired_wr = 1'b0;
    assign wired_q  = '0;
`endif

    // Random counts down each cycle and reloads to the top entry at the Wired boundary (or 0).
    always_ff @(posedge clk) begin
        if (rst || wired_wr || (random_q == wired_q) || (random_q == '0))
            random_q <= IDX_MAX;
        else
            random_q <= random_q - 1'b1;
    end

    // Index: probe result wins over MTC0; a probe miss keeps the old entry number.
    always_ff @(posedge clk) begin
        if (rst) begin
            index_p   <= 1'b0;
            index_idx <= '0;
        end else if (cap_p) begin
            index_p <= Index_i[31];
            if (!Index_i[31])
                index_idx <= Index_i[IDX_W-1:0];
        end else if (wr_index) begin
            index_p   <= 1'b0;
            index_idx <= cp0_wdata[IDX_W-1:0];
        end
    end

    // EntryHi: exception VPN2 load keeps ASID; otherwise TLBR result, then MTC0.
    always_ff @(posedge clk) begin
        if (rst)          entryhi_q <= 32'h0;
        else if (exc_tlb) entryhi_q <= {exc_vaddr[31:13], entryhi_q[12:0]};
        else if (cap_r)   entryhi_q <= EntryHi_i & ENTRYHI_MASK;
        else if (wr_hi)   entryhi_q <= cp0_wdata & ENTRYHI_MASK;
    end

    // EntryLo0/1 and PageMask: TLBR result over MTC0.
    always_ff @(posedge clk) begin
        if (rst) begin
            entrylo0_q <= 32'h0;
            entrylo1_q <= 32'h0;
            pagemask_q <= 32'h0;
        end else if (cap_r) begin
            entrylo0_q <= EntryLo0_i & ENTRYLO_MASK;
            entrylo1_q <= EntryLo1_i & ENTRYLO_MASK;
            pagemask_q <= PageMask_i & PAGEMASK_MASK;
        end else begin
            if (wr_lo0)   entrylo0_q <= cp0_wdata & ENTRYLO_MASK;
            if (wr_lo1)   entrylo1_q <= cp0_wdata & ENTRYLO_MASK;
            if (wr_pmask) pagemask_q <= cp0_wdata & PAGEMASK_MASK;
        end
    end

    // Context PTEBase is software-written; BadVPN2 and BadVAddr come only from exceptions.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctx_ptebase <= '0;
            ctx_badvpn2 <= '0;
            badvaddr_q  <= 32'h0;
        end else begin
            if (wr_ctx)
                ctx_ptebase <= cp0_wdata[31:23];
            if (exc_tlb) begin
                ctx_badvpn2 <= exc_vaddr[31:13];
                badvaddr_q  <= exc_vaddr;
            end
        end
    end

    assign context_val = {ctx_ptebase, ctx_badvpn2, 4'b0000};
    assign wired_val   = {{(32-IDX_W){1'b0}}, wired_q};

    assign Index_o    = {index_p, {(31-IDX_W){1'b0}}, index_idx};
    assign Random_o   = {{(32-IDX_W){1'b0}}, random_q};
    assign EntryHi_o  = entryhi_q;
    assign EntryLo0_o = entrylo0_q;
    assign EntryLo1_o = entrylo1_q;
    assign PageMask_o = pagemask_q;

    // MFC0 read mux straight from register state.
    always_comb begin
        cp0_rdata = 32'h0;
        case (cp0_raddr)
            REG_INDEX:    cp0_rdata = Index_o;
            REG_RANDOM:   cp0_rdata = Random_o;
            REG_ENTRYLO0: cp0_rdata = entrylo0_q;
            REG_ENTRYLO1: cp0_rdata = entrylo1_q;
            REG_CONTEXT:  cp0_rdata = context_val;
            REG_PAGEMASK: cp0_rdata = pagemask_q;
            REG_WIRED:    cp0_rdata = wired_val;
            REG_BADVADDR: cp0_rdata = badvaddr_q;
            REG_ENTRYHI:  cp0_rdata = entryhi_q;
            default:      cp0_rdata = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_cp0_tlb_regs.sv
// Self-checking bench for cp0_tlb_regs against an architectural register model.
// Inputs are driven 1 time unit after the rising edge; registers are read at the falling edge.
// Random is predicted from cycles elapsed since its last reload rather than by stepping a counter.
module tb_cp0_tlb_regs;

    localparam int          N    = 16;
    localparam logic [31:0] IDXM = 32'(N - 1);
`ifdef TLB_WIRED_EN
    localparam bit WIRED_EN = 1'b1;
`else
    localparam bit WIRED_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cp0_we = 1'b0;
    logic [4:0]  cp0_waddr = '0;
    logic [31:0] cp0_wdata = '0;
    logic [4:0]  cp0_raddr = '0;
    logic [31:0] cp0_rdata;
    logic        tlbp_req = 1'b0, tlbr_req = 1'b0, tlbwi_req = 1'b0, tlbwr_req = 1'b0;
    logic        tlb_busy, TLBP, TLBR, TLBWI, TLBWR;
    logic [31:0] EntryHi_o, PageMask_o, EntryLo0_o, EntryLo1_o, Index_o, Random_o;
    logic [31:0] EntryHi_i = '0, PageMask_i = '0, EntryLo0_i = '0, EntryLo1_i = '0, Index_i = '0;
    logic        exc_tlb = 1'b0;
    logic [31:0] exc_vaddr = '0;

    cp0_tlb_regs #(.TLB_ENTRIES(N)) dut (
        .clk(clk), .rst(rst),
        .cp0_we(cp0_we), .cp0_waddr(cp0_waddr), .cp0_wdata(cp0_wdata),
        .cp0_raddr(cp0_raddr), .cp0_rdata(cp0_rdata),
        .tlbp_req(tlbp_req), .tlbr_req(tlbr_req), .tlbwi_req(tlbwi_req), .tlbwr_req(tlbwr_req),
        .tlb_busy(tlb_busy), .TLBP(TLBP), .TLBR(TLBR), .TLBWI(TLBWI), .TLBWR(TLBWR),
        .EntryHi_o(EntryHi_o), .PageMask_o(PageMask_o), .EntryLo0_o(EntryLo0_o),
        .EntryLo1_o(EntryLo1_o), .Index_o(Index_o), .Random_o(Random_o),
        .EntryHi_i(EntryHi_i), .PageMask_i(PageMask_i), .EntryLo0_i(EntryLo0_i),
        .EntryLo1_i(EntryLo1_i), .Index_i(Index_i),
        .exc_tlb(exc_tlb), .exc_vaddr(exc_vaddr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_reg [0:31];
    int          m_wired;
    int          rand_base;

    function automatic logic [31:0] wmask(input int a);
        case (a)
            0:       return IDXM;
            2, 3:    return 32'h03FF_FFFF;
            4:       return 32'hFF80_0000;
            5:       return 32'h01FF_E000;
            6:       return WIRED_EN ? IDXM : 32'h0;
            10:      return 32'hFFFF_E0FF;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] exp_random();
        return 32'((N - 1) - ((cyc - rand_base) % (N - m_wired)));
    endfunction

    function automatic logic [31:0] exp_reg(input int a);
        return (a == 1) ? exp_random() : m_reg[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_reg[i] = 32'h0;
        m_wired   = 0;
        rand_base = cyc;
    endtask

    task automatic model_exc(input logic [31:0] v);
        m_reg[8]  = v;
        m_reg[10] = (v & 32'hFFFF_E000) | (m_reg[10] & 32'h0000_1FFF);
        m_reg[4]  = (m_reg[4] & 32'hFF80_0000) | ((v >> 13) << 4);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
    endtask

    task automatic do_read(input logic [4:0] a, output logic [31:0] v);
        @(negedge clk);
        cp0_raddr = a;
        #1;
        v = cp0_rdata;
    endtask

    task automatic mtc0(input int a, input logic [31:0] d);
        logic [31:0] wm;
        cp0_we    = 1'b1;
        cp0_waddr = 5'(a);
        cp0_wdata = d;
        tick();
        cp0_we = 1'b0;
        wm = wmask(a);
        if (a == 0) m_reg[0] = d & wm;
        else        m_reg[a] = (m_reg[a] & ~wm) | (d & wm);
        if (a == 6 && WIRED_EN) begin
            m_wired   = int'(d & IDXM);
            rand_base = cyc;
        end
    endtask

    task automatic test_reset();
        logic [31:0] v;
        rst = 1'b1;
        repeat (3) tick();
        apply_reset();
        checks++;
        if ({tlb_busy, TLBP, TLBR, TLBWI, TLBWR} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 00000", {tlb_busy, TLBP, TLBR, TLBWI, TLBWR});
        end
        checks++;
        if (Random_o !== 32'd15) begin
            errors++;
            $display("FAIL reset_random_o: got %0d expected 15", Random_o);
        end
        for (int a = 0; a < 32; a++) begin
            do_read(5'(a), v);
            checks++;
            if (v !== exp_reg(a)) begin
                errors++;
                $display("FAIL reset_reg%0d: got %h expected %h", a, v, exp_reg(a));
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] v;
        apply_reset();
        do_read(5'd1, v);
        checks++;
        if (v !== 32'd15) begin
            errors++;
            $display("FAIL random_after_reset: got %0d expected 15", v);
        end
        repeat (16) @(posedge clk);
        do_read(5'd1, v);
        checks++;
        if (v !== 32'd15) begin
            errors++;
            $display("FAIL random_wrap16: got %0d expected 15", v);
        end
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 40)) @(posedge clk);
            do_read(5'd1, v);
            checks++;
            if (v !== exp_random()) begin
                errors++;
                $display("FAIL random_seq%0d: got %0d expected %0d", i, v, exp_random());
            end
        end
    endtask

    task automatic test_wired();
        logic [31:0] v;
        logic [31:0] e;
        mtc0(6, 32'd4);
`ifdef TLB_WIRED_EN
        for (int k = 0; k < 13; k++) begin
            do_read(5'd1, v);
            e = (k < 12) ? 32'(15 - k) : 32'd15;
            checks++;
            if (v !== e) begin
                errors++;
                $display("FAIL wired_random_seq%0d: got %0d expected %0d", k, v, e);
            end
        end
        do_read(5'd6, v);
        checks++;
        if (v !== 32'd4) begin
            errors++;
            $display("FAIL wired_read: got %0d expected 4", v);
        end
        mtc0(6, 32'd0);
`else
        do_read(5'd6, v);
        checks++;
        if (v !== 32'd0) begin
            errors++;
            $display("FAIL wired_absent_read: got %0d expected 0", v);
        end
        for (int k = 0; k < 13; k++) begin
            do_read(5'd1, v);
            checks++;
            if (v !== exp_random()) begin
                errors++;
                $display("FAIL wired_absent_random%0d: got %0d expected %0d", k, v, exp_random());
            end
        end
`endif
    endtask

    task automatic test_mtc0();
        logic [31:0] v;
        for (int i = 0; i < 40; i++) mtc0($urandom_range(0, 15), $urandom);
        for (int a = 0; a < 16; a++) begin
            do_read(5'(a), v);
            checks++;
            if (v !== exp_reg(a)) begin
                errors++;
                $display("FAIL mtc0_reg%0d: got %h expected %h", a, v, exp_reg(a));
            end
        end
        mtc0(6, 32'd0);
    endtask

    task automatic run_tlbp(input logic [31:0] iv, input string tag);
        logic [31:0] v;
        Index_i  = iv;
        tlbp_req = 1'b1;
        tick();
        tlbp_req = 1'b0;
        checks++;
        if ({tlb_busy, TLBP, TLBR, TLBWI, TLBWR} !== 5'b11000) begin
            errors++;
            $display("FAIL %s_issue: got %b expected 11000", tag, {tlb_busy, TLBP, TLBR, TLBWI, TLBWR});
        end
        tick();
        checks++;
        if ({tlb_busy, TLBP} !== 2'b10) begin
            errors++;
            $display("FAIL %s_capture: got %b expected 10", tag, {tlb_busy, TLBP});
        end
        tick();
        checks++;
        if (tlb_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle_busy: got %b expected 0", tag, tlb_busy);
        end
        if (iv[31]) m_reg[0] = 32'h8000_0000 | (m_reg[0] & IDXM);
        else        m_reg[0] = iv & IDXM;
        do_read(5'd0, v);
        checks++;
        if (v !== m_reg[0] || Index_o !== m_reg[0]) begin
            errors++;
            $display("FAIL %s_index: got %h/%h expected %h", tag, v, Index_o, m_reg[0]);
        end
    endtask

    task automatic test_tlbp();
        logic [31:0] v;
        run_tlbp(32'h0000_0005, "tlbp_hit");
        checks++;
        if (m_reg[0] !== 32'h5 || Index_o !== 32'h0000_0005) begin
            errors++;
            $display("FAIL tlbp_hit_const: got %h expected 00000005", Index_o);
        end
        run_tlbp(32'h8000_0000, "tlbp_miss");
        checks++;
        if (Index_o !== 32'h8000_0005) begin
            errors++;
            $display("FAIL tlbp_miss_const: got %h expected 80000005", Index_o);
        end
        mtc0(0, 32'h8000_0003);
        do_read(5'd0, v);
        checks++;
        if (v !== 32'h0000_0003) begin
            errors++;
            $display("FAIL mtc0_index_clears_p: got %h expected 00000003", v);
        end
        for (int i = 0; i < 8; i++) run_tlbp($urandom, "tlbp_rand");
    endtask

    task automatic run_tlbr(input logic [31:0] hi, input logic [31:0] pm,
                            input logic [31:0] lo0, input logic [31:0] lo1, input string tag);
        logic [31:0] v;
        EntryHi_i = ~hi; PageMask_i = ~pm; EntryLo0_i = ~lo0; EntryLo1_i = ~lo1;
        tlbr_req = 1'b1;
        tick();
        tlbr_req = 1'b0;
        checks++;
        if ({tlb_busy, TLBP, TLBR, TLBWI, TLBWR} !== 5'b10100) begin
            errors++;
            $display("FAIL %s_issue: got %b expected 10100", tag, {tlb_busy, TLBP, TLBR, TLBWI, TLBWR});
        end
        tick();
        EntryHi_i = hi; PageMask_i = pm; EntryLo0_i = lo0; EntryLo1_i = lo1;
        tick();
        m_reg[10] = hi & 32'hFFFF_E0FF;
        m_reg[5]  = pm & 32'h01FF_E000;
        m_reg[2]  = lo0 & 32'h03FF_FFFF;
        m_reg[3]  = lo1 & 32'h03FF_FFFF;
        checks++;
        if ({EntryHi_o, PageMask_o, EntryLo0_o, EntryLo1_o} !== {m_reg[10], m_reg[5], m_reg[2], m_reg[3]}) begin
            errors++;
            $display("FAIL %s_outs: got %h %h %h %h expected %h %h %h %h", tag, EntryHi_o, PageMask_o,
                     EntryLo0_o, EntryLo1_o, m_reg[10], m_reg[5], m_reg[2], m_reg[3]);
        end
        do_read(5'd2, v);
        checks++;
        if (v !== m_reg[2]) begin
            errors++;
            $display("FAIL %s_read_lo0: got %h expected %h", tag, v, m_reg[2]);
        end
    endtask

    task automatic test_tlbr();
        run_tlbr(32'hFFFF_FFFF, $urandom, 32'hFFFF_FFFF, $urandom, "tlbr_ones");
        checks++;
        if (EntryLo0_o !== 32'h03FF_FFFF || EntryHi_o !== 32'hFFFF_E0FF) begin
            errors++;
            $display("FAIL tlbr_ones_const: got %h %h expected 03ffffff ffffe0ff", EntryLo0_o, EntryHi_o);
        end
        for (int i = 0; i < 6; i++) run_tlbr($urandom, $urandom, $urandom, $urandom, "tlbr_rand");
    endtask

    task automatic test_tlbw();
        tlbwr_req = 1'b1;
        tick();
        tlbwr_req = 1'b0;
        checks++;
        if ({tlb_busy, TLBP, TLBR, TLBWI, TLBWR} !== 5'b10001 || Random_o !== exp_random()) begin
            errors++;
            $display("FAIL tlbwr_issue: got %b rnd %0d expected 10001 rnd %0d",
                     {tlb_busy, TLBP, TLBR, TLBWI, TLBWR}, Random_o, exp_random());
        end
        tick();
        checks++;
        if ({tlb_busy, TLBWR} !== 2'b00) begin
            errors++;
            $display("FAIL tlbwr_done: got %b expected 00", {tlb_busy, TLBWR});
        end
    endtask

    task automatic test_back_to_back();
        tlbwi_req = 1'b1;
        tick();
        tlbwi_req = 1'b0;
        tick();
        tlbwr_req = 1'b1;
        tick();
        tlbwr_req = 1'b0;
        checks++;
        if ({tlb_busy, TLBWI, TLBWR} !== 3'b101) begin
            errors++;
            $display("FAIL b2b_second_issue: got %b expected 101", {tlb_busy, TLBWI, TLBWR});
        end
        tick();
        tlbp_req = 1'b1;
        Index_i  = 32'h0000_0007;
        tick();
        tlbp_req = 1'b0;
        checks++;
        if ({tlb_busy, TLBP, TLBWR} !== 3'b110) begin
            errors++;
            $display("FAIL b2b_third_issue: got %b expected 110", {tlb_busy, TLBP, TLBWR});
        end
        repeat (2) tick();
        m_reg[0] = 32'h7;
    endtask

    task automatic test_busy_ignore();
        logic [31:0] iv;
        iv       = $urandom & 32'h8000_000F;
        Index_i  = iv;
        tlbp_req = 1'b1;
        tick();
        tlbp_req  = 1'b0;
        tlbwi_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (k == 1) tlbwi_req = 1'b0;
            checks++;
            if (TLBWI !== 1'b0) begin
                errors++;
                $display("FAIL busy_ignore_wi%0d: got %b expected 0", k, TLBWI);
            end
        end
        if (iv[31]) m_reg[0] = 32'h8000_0000 | (m_reg[0] & IDXM);
        else        m_reg[0] = iv & IDXM;
        checks++;
        if (Index_o !== m_reg[0] || tlb_busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_ignore_index: got %h busy %b expected %h busy 0", Index_o, tlb_busy, m_reg[0]);
        end
    endtask

    task automatic test_exc();
        logic [31:0] v;
        logic [31:0] va;
        mtc0(10, 32'h0000_002A);
        mtc0(4, $urandom);
        exc_tlb   = 1'b1;
        exc_vaddr = 32'h1234_5678;
        tick();
        exc_tlb = 1'b0;
        model_exc(32'h1234_5678);
        do_read(5'd8, v);
        checks++;
        if (v !== 32'h1234_5678) begin
            errors++;
            $display("FAIL exc_badvaddr: got %h expected 12345678", v);
        end
        do_read(5'd10, v);
        checks++;
        if (v !== 32'h1234_402A) begin
            errors++;
            $display("FAIL exc_entryhi: got %h expected 1234402a", v);
        end
        do_read(5'd4, v);
        checks++;
        if (v[22:4] !== 19'h091A2 || v !== m_reg[4]) begin
            errors++;
            $display("FAIL exc_context: got %h expected %h", v, m_reg[4]);
        end
        for (int i = 0; i < 4; i++) begin
            va        = $urandom;
            exc_tlb   = 1'b1;
            exc_vaddr = va;
            tick();
            exc_tlb = 1'b0;
            model_exc(va);
            for (int a = 4; a <= 10; a += 2) begin
                do_read(5'(a), v);
                checks++;
                if (v !== m_reg[a]) begin
                    errors++;
                    $display("FAIL exc_rand_reg%0d: got %h expected %h", a, v, m_reg[a]);
                end
            end
        end
    endtask

    task automatic test_exc_capture();
        logic [31:0] v;
        logic [31:0] va;
        mtc0(2, $urandom);
        EntryHi_i = $urandom; PageMask_i = $urandom; EntryLo0_i = ~m_reg[2]; EntryLo1_i = $urandom;
        tlbr_req = 1'b1;
        tick();
        tlbr_req = 1'b0;
        tick();
        checks++;
        if (tlb_busy !== 1'b1) begin
            errors++;
            $display("FAIL exccap_busy_capture: got %b expected 1", tlb_busy);
        end
        va        = $urandom;
        exc_tlb   = 1'b1;
        exc_vaddr = va;
        tick();
        exc_tlb = 1'b0;
        model_exc(va);
        checks++;
        if (tlb_busy !== 1'b0) begin
            errors++;
            $display("FAIL exccap_busy_drop: got %b expected 0", tlb_busy);
        end
        for (int a = 2; a <= 10; a++) begin
            do_read(5'(a), v);
            checks++;
            if (v !== exp_reg(a)) begin
                errors++;
                $display("FAIL exccap_reg%0d: got %h expected %h", a, v, exp_reg(a));
            end
        end
        Index_i  = 32'h0000_0009;
        tlbp_req = 1'b1;
        tick();
        tlbp_req = 1'b0;
        exc_tlb  = 1'b1;
        va       = $urandom;
        exc_vaddr = va;
        tick();
        exc_tlb = 1'b0;
        model_exc(va);
        checks++;
        if ({tlb_busy, TLBP} !== 2'b00) begin
            errors++;
            $display("FAIL excissue_abort: got %b expected 00", {tlb_busy, TLBP});
        end
        repeat (2) tick();
        checks++;
        if (Index_o !== m_reg[0]) begin
            errors++;
            $display("FAIL excissue_index: got %h expected %h", Index_o, m_reg[0]);
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] v;
        EntryHi_i = 32'hFFFF_FFFF; PageMask_i = 32'hFFFF_FFFF;
        EntryLo0_i = 32'hFFFF_FFFF; EntryLo1_i = 32'hFFFF_FFFF;
        tlbr_req = 1'b1;
        tick();
        tlbr_req = 1'b0;
        apply_reset();
        checks++;
        if ({tlb_busy, TLBP, TLBR, TLBWI, TLBWR} !== 5'b0) begin
            errors++;
            $display("FAIL rstabort_ctrl: got %b expected 00000", {tlb_busy, TLBP, TLBR, TLBWI, TLBWR});
        end
        tick();
        for (int a = 1; a <= 5; a++) begin
            do_read(5'(a), v);
            checks++;
            if (v !== exp_reg(a)) begin
                errors++;
                $display("FAIL rstabort_reg%0d: got %h expected %h", a, v, exp_reg(a));
            end
        end
        checks++;
        if (EntryHi_o !== 32'h0) begin
            errors++;
            $display("FAIL rstabort_entryhi: got %h expected 0", EntryHi_o);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_random();
        test_wired();
        test_mtc0();
        test_tlbp();
        test_tlbr();
        test_tlbw();
        test_back_to_back();
        test_busy_ignore();
        test_exc();
        test_exc_capture();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cp0_tlb_regs.md
CP0_TLB_REGS -- requirements
Module: cp0_tlb_regs

Interface
REQ-001 Parameter TLB_ENTRIES, default 16, meaning TLB entry count; power of two, 4..32; IDX_W = log2(TLB_ENTRIES).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 cp0_we / cp0_waddr / cp0_wdata  in  1/5/32  MTC0 write strobe, register number, data.
REQ-005 cp0_raddr / cp0_rdata  in/out  5/32  MFC0 read address; combinational read data.
REQ-006 tlbp_req, tlbr_req, tlbwi_req, tlbwr_req  in  1 each  one-cycle TLB instruction requests from the M stage; at most one high per cycle.
REQ-007 tlb_busy  out  1  stall request to pipeline while an instruction is in flight.
REQ-008 TLBP, TLBR, TLBWI, TLBWR  out  1 each  one-cycle command pulses to the translation unit.
REQ-009 EntryHi_o, PageMask_o, EntryLo0_o, EntryLo1_o, Index_o, Random_o  out  32 each  register values driven to the translation unit.
REQ-010 EntryHi_i, PageMask_i, EntryLo0_i, EntryLo1_i, Index_i  in  32 each  TLBR/TLBP results, valid the cycle after the command pulse.
REQ-011 exc_tlb  in  1  TLB refill/invalid/modify exception commit strobe; exc_vaddr in 32 faulting address.

Function
REQ-012 Registers (number): Index(0), Random(1), EntryLo0(2), EntryLo1(3), Context(4), PageMask(5), Wired(6), BadVAddr(8), EntryHi(10); other addresses read 0, writes ignored.
REQ-013 Writable masks: Index[IDX_W-1:0]; EntryLo[25:0]; Context[31:23]; PageMask[24:13]; Wired[IDX_W-1:0]; EntryHi[31:13] and [7:0]; non-writable bits read 0; Random, BadVAddr read-only.
REQ-014 FSM states IDLE, ISSUE, CAPTURE; IDLE->ISSUE on any req; ISSUE->CAPTURE for TLBP/TLBR, ISSUE->IDLE for TLBWI/TLBWR; CAPTURE->IDLE unconditionally.
REQ-015 Command pulse asserted exactly in ISSUE; tlb_busy high in ISSUE and CAPTURE; requests arriving while busy are ignored.
REQ-016 TLBP capture: Index[31] = Index_i[31]; Index[IDX_W-1:0] = Index_i[IDX_W-1:0] on hit, unchanged on miss.
REQ-017 TLBR capture: EntryHi, PageMask, EntryLo0, EntryLo1 loaded from inputs through REQ-013 masks.
REQ-018 Random: decrements by 1 every cycle; at value == Wired (or 0) next value is TLB_ENTRIES-1; TLBWR in ISSUE uses the current Random_o value.
REQ-019 MTC0 Wired sets Random to TLB_ENTRIES-1 next cycle; MTC0 Index clears Index[31].
REQ-020 exc_tlb: BadVAddr <= exc_vaddr; EntryHi[31:13] <= exc_vaddr[31:13] (ASID unchanged); Context[22:4] <= exc_vaddr[31:13].
REQ-021 Priority same cycle on one register: exc_tlb > TLBP/TLBR capture > MTC0.
REQ-022 exc_tlb in ISSUE or CAPTURE: FSM returns to IDLE, pending capture discarded; command pulse already issued not retracted.
REQ-023 cp0_rdata reflects register state only (no bypass of same-cycle write).

Reset
REQ-024 rst: FSM IDLE; tlb_busy and all command pulses 0; Random = TLB_ENTRIES-1; Wired, Index, EntryHi, EntryLo0/1, PageMask, Context, BadVAddr = 0.
REQ-025 rst asserted mid-instruction aborts it; no capture occurs the following cycle.

Configuration
REQ-026 Macro TLB_WIRED_EN: defined -> Wired implemented per REQ-013/018/019; undefined -> Wired reads 0, writes ignored, Random wraps from 0 to TLB_ENTRIES-1.

Verification
REQ-027 Reset then read Random -> 15; 16 cycles later -> 15 again (wrap at 0).
REQ-028 MTC0 Wired=4 (TLB_WIRED_EN) -> Random 15 next cycle, sequence 15..4 then 15; without macro Wired reads 0.
REQ-029 tlbp_req, Index_i=0x0000_0005 -> TLBP pulse 1 cycle, busy 2 cycles, Index=0x5; then Index_i=0x8000_0000 -> Index=0x8000_0005.
REQ-030 tlbr_req, EntryLo0_i=0xFFFF_FFFF -> EntryLo0=0x03FF_FFFF; EntryHi_i=0xFFFF_FFFF -> EntryHi=0xFFFF_E0FF.
REQ-031 exc_tlb with exc_vaddr=0x1234_5678, EntryHi ASID=0x2A -> BadVAddr=0x1234_5678, EntryHi=0x1234_402A, Context[22:4]=0x091A2.
REQ-032 exc_tlb in CAPTURE of TLBR -> EntryLo0 unchanged, busy drops next cycle; tlbwi_req during busy -> no TLBWI pulse.
